weight_bpe_loader: RTL
======================

WEIGHT_BPE_LOADER -- requirements
Module: weight_bpe_loader

Interface
REQ-001 SHALL have parameters (name, default, meaning): num_pe_col, 1, PE columns; nb_taps, 11, taps per column; weight_width, 16, weight bits; ETC_width, 4, effective-term-count bits; weight_bpr_width, ((weight_width+1)/2)*3, encoded bits per tap; G = (weight_width+1)/2 groups per weight.
REQ-002 SHALL have port clk, input, 1, single clock, rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port load_start, input, 1, begin a load job.
REQ-005 SHALL have port reenc_start, input, 1, begin re-encoding the held weights.
REQ-006 SHALL have port abort, input, 1, cancel a load or re-encode job.
REQ-007 SHALL have port kernel_size, input, 4, taps per column (1..nb_taps).
REQ-008 SHALL have port num_cols, input, $clog2(num_pe_col+1), active columns.
REQ-009 SHALL have port n_ap, input, 4, low groups to drop.
REQ-010 SHALL have port w_valid, input, 1, weight word valid.
REQ-011 SHALL have port w_data, input, weight_width, weight in two's complement.
REQ-012 SHALL have port w_ready, output, 1, loader accepts a weight.
REQ-013 SHALL have ports WRegs, WBPRs and WETCs as outputs [num_pe_col][weight_width*nb_taps], [num_pe_col][weight_bpr_width*nb_taps] and [num_pe_col][ETC_width*nb_taps], each registered, tap t at slice [t*width +: width].
REQ-014 SHALL have port busy, output, 1, job in progress.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, CLEAR, LOAD, REENC and DONE.
REQ-017 SHALL, in IDLE, on load_start latch kernel_size, num_cols and n_ap and go to CLEAR; if load_start and reenc_start are both high, load_start wins.
REQ-018 SHALL, in IDLE, on reenc_start (without load_start) latch n_ap and go to REENC.
REQ-019 SHALL ignore load_start and reenc_start outside IDLE.
REQ-020 SHALL clamp a latched kernel_size of 0 or greater than nb_taps to nb_taps, and a num_cols of 0 or greater than num_pe_col to num_pe_col.
REQ-021 SHALL, in CLEAR, zero all taps of all columns in one cycle, then go to LOAD.
REQ-022 SHALL drive w_ready high only in LOAD, combinationally from the state.
REQ-023 SHALL treat a cycle with w_valid and w_ready both high as a handshake that writes w_data, its BPR and its ETC to (col_cnt, tap_cnt), visible on the outputs one cycle later.
REQ-024 SHALL increment tap_cnt on each handshake; at kernel_size-1 it SHALL wrap tap_cnt to 0 and increment col_cnt.
REQ-025 SHALL go to DONE on the handshake at (num_cols-1, kernel_size-1).
REQ-026 SHALL leave taps kernel_size..nb_taps-1 and columns num_cols..num_pe_col-1 at zero.
REQ-027 SHALL, in REENC, recompute WBPRs and WETCs of every tap of one column per cycle from WRegs using the new n_ap, for columns 0..num_pe_col-1, then go to DONE; WRegs SHALL be unchanged.
REQ-028 SHALL encode each group i in 0..G-1 as follows:
- i >= n_ap: bpr[3i+1] = w[2i]; bpr[3i+2] = w[2i+1]; bpr[3i] = (i==0 ? 0 : w[2i-1]).
- i < n_ap: bpr[3i+2:3i] = 000.
- A bit index >= weight_width SHALL take the sign bit w[weight_width-1].
REQ-029 SHALL set ETC to the number of groups whose 3-bit code is neither 000 nor 111; parameters SHALL satisfy 2^ETC_width > G.
REQ-030 SHALL, in DONE, hold done high for exactly one cycle and then return to IDLE.
REQ-031 SHALL hold busy high in CLEAR, LOAD and REENC.
REQ-032 SHALL, on abort in LOAD or REENC, return to IDLE the next cycle with no done pulse, keep partially written registers, and not write the handshake of the abort cycle.

Reset
REQ-033 SHALL, on rst (asynchronous, any state including mid-job), set the FSM to IDLE, clear all counters and drive WRegs, WBPRs, WETCs, w_ready, busy and done to 0.
REQ-034 SHALL leave the FSM in IDLE after rst deasserts, with no done pulse.

Verification
REQ-035 Load, kernel_size=3, num_cols=1, n_ap=0, weights 1,2,3 -> WRegs taps 1/2/3; WBPR low 6 bits 000010, 001100, 001110; ETCs 1, 2, 2; done one cycle after the third handshake.
REQ-036 Load w_data=16'hFFFF with n_ap=0, then reenc_start with n_ap=1 -> ETC 1 then 0; WBPR tap0 24'hFFFFFE then 24'hFFFFF8; WRegs unchanged.
REQ-037 Load num_pe_col=2, kernel_size=2, w_valid toggling every cycle -> tap order c0t0, c0t1, c1t0, c1t1; no writes on w_valid=0 cycles; taps 2..10 zero.
REQ-038 Load with kernel_size=0 -> 11 handshakes accepted before done.
REQ-039 Abort after 2 of 3 handshakes -> taps 0-1 written, tap2 zero, no done pulse, busy low the next cycle; a following load_start runs normally.
REQ-040 rst asserted mid-LOAD -> all outputs 0 immediately without a clock edge; load_start after rst deasserts completes normally.

Source files
------------

// File: rtl/weight_bpe_loader.sv
// weight_bpe_loader
// Loads signed weights into per-column tap registers and keeps, next to each
// weight, its booth-pair radix (BPR) encoding and effective-term count (ETC).
// A load job clears every tap and then accepts kernel_size*num_cols weights
// in column-major order (tap fastest). A re-encode job recomputes BPR/ETC
// of every tap from the held weights with a new n_ap, one column per cycle.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   load_start        : start a load job (wins over reenc_start)
//   reenc_start       : start a re-encode job
//   abort             : cancel a running load / re-encode job
//   kernel_size       : taps per column, 0 or >nb_taps means nb_taps
//   num_cols          : active columns, 0 or >num_pe_col means num_pe_col
//   n_ap              : number of low groups forced to code 000
//   w_valid / w_ready : weight handshake (w_ready combinational from state)
//   w_data            : two's complement weight
//   WRegs/WBPRs/WETCs : per-column registers, tap t at [t*width +: width]
//   busy              : high in CLEAR, LOAD and REENC
//   done              : one-cycle pulse when a job completes
//   dbg_state         : current FSM state
//
// Handshake: a weight transfers on a rising clk edge where w_valid and
// w_ready are both high and abort is low; w_valid may be dropped at any time
// and the data is only sampled on a transfer cycle.
//
// Encoding: group i covers w[2i+1], w[2i], w[2i-1] (w[-1] = 0, bits above
// the MSB read as the sign bit). ETC_width must satisfy 2**ETC_width > G.
module weight_bpe_loader #(
  parameter int num_pe_col       = 1,
  parameter int nb_taps          = 11,
  parameter int weight_width     = 16,
  parameter int ETC_width        = 4,
  parameter int weight_bpr_width = ((weight_width + 1) / 2) * 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_start,
  input  logic                                 reenc_start,
  input  logic                                 abort,
  input  logic [3:0]                           kernel_size,
  input  logic [$clog2(num_pe_col+1)-1:0]      num_cols,
  input  logic [3:0]                           n_ap,
  input  logic                                 w_valid,
  input  logic [weight_width-1:0]              w_data,
  output logic                                 w_ready,
  output logic [weight_width*nb_taps-1:0]      WRegs [num_pe_col],
  output logic [weight_bpr_width*nb_taps-1:0]  WBPRs [num_pe_col],
  output logic [ETC_width*nb_taps-1:0]         WETCs [num_pe_col],
  output logic                                 busy,
  output logic                                 done,
  output logic [2:0]                           dbg_state
);

  localparam int G   = (weight_width + 1) / 2;
  localparam int NCW = $clog2(num_pe_col + 1);
  localparam int CIW = (num_pe_col > 1) ? $clog2(num_pe_col) : 1;
  localparam int WW  = weight_width;
  localparam int BW  = weight_bpr_width;
  localparam int EW  = ETC_width;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_REENC = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     ks_q;
  logic [3:0]     nap_q;
  logic [NCW-1:0] nc_q;
  logic [NCW-1:0] col_cnt;
  logic [3:0]     tap_cnt;
  logic [CIW-1:0] col_idx;
  logic           hs, tap_last, col_last, reenc_last;

  // Bit idx of w; indices past the MSB read as the sign bit.
  function automatic logic wbit(input logic [WW-1:0] w, input int idx);
    logic [WW-1:0] s;
    if (idx >= WW) return w[WW-1];
    s = w >> idx;
    return s[0];
  endfunction

  function automatic logic [BW-1:0] encode_bpr(input logic [WW-1:0] w,
                                               input logic [3:0]  nap);
    logic [BW-1:0] b;
    logic [2:0]    code;
    b = '0;
    for (int i = 0; i < G; i++) begin
      code = '0;
      if (i >= int'(nap)) begin
        code[0] = (i == 0) ? 1'b0 : wbit(w, 2*i - 1);
        code[1] = wbit(w, 2*i);
        code[2] = wbit(w, 2*i + 1);
      end
      b = b | (BW'(code) << (3*i));
    end
    return b;
  endfunction

  // Codes 000 and 111 contribute no partial product.
  function automatic logic [EW-1:0] count_etc(input logic [BW-1:0] b);
    logic [EW-1:0] n;
    logic [2:0]    code;
    n = '0;
    for (int i = 0; i < G; i++) begin
      code = 3'(b >> (3*i));
      if (code != 3'b000 && code != 3'b111) n = n + EW'(1);
    end
    return n;
  endfunction

  assign col_idx    = col_cnt[CIW-1:0];
  assign hs         = (state_q == S_LOAD) && w_valid && !abort;
  assign tap_last   = (tap_cnt == ks_q - 4'd1);
  assign col_last   = (col_cnt == nc_q - NCW'(1));
  assign reenc_last = (col_cnt == NCW'(num_pe_col - 1));
  assign dbg_state  = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    w_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start)       state_d = S_CLEAR;
        else if (reenc_start) state_d = S_REENC;
      end
      S_CLEAR: begin
        busy    = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        if (abort)                             state_d = S_IDLE;
        else if (hs && tap_last && col_last)   state_d = S_DONE;
      end
      S_REENC: begin
        busy = 1'b1;
        if (abort)           state_d = S_IDLE;
        else if (reenc_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_q    <= '0;
      nc_q    <= '0;
      nap_q   <= '0;
      col_cnt <= '0;
      tap_cnt <= '0;
      for (int c = 0; c < num_pe_col; c++) begin
        WRegs[c] <= '0;
        WBPRs[c] <= '0;
        WETCs[c] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          col_cnt <= '0;
          tap_cnt <= '0;
          if (load_start) begin
            ks_q  <= (kernel_size == 4'd0 || int'(kernel_size) > nb_taps)
                     ? 4'(nb_taps) : kernel_size;
            nc_q  <= (num_cols == '0 || int'(num_cols) > num_pe_col)
                     ? NCW'(num_pe_col) : num_cols;
            nap_q <= n_ap;
          end else if (reenc_start) begin
            nap_q <= n_ap;
          end
        end
        S_CLEAR: begin
          for (int c = 0; c < num_pe_col; c++) begin
            WRegs[c] <= '0;
            WBPRs[c] <= '0;
            WETCs[c] <= '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            WRegs[col_idx][tap_cnt*WW +: WW] <= w_data;
            WBPRs[col_idx][tap_cnt*BW +: BW] <= encode_bpr(w_data, nap_q);
            WETCs[col_idx][tap_cnt*EW +: EW] <= count_etc(encode_bpr(w_data, nap_q));
            if (tap_last) begin
              tap_cnt <= '0;
              col_cnt <= col_cnt + NCW'(1);
            end else begin
              tap_cnt <= tap_cnt + 4'd1;
            end
          end
        end
        S_REENC: begin
          // Weights stay put; only the derived encodings of one column move.
          if (!abort) begin
            for (int t = 0; t < nb_taps; t++) begin
              WBPRs[col_idx][t*BW +: BW] <= encode_bpr(WRegs[col_idx][t*WW +: WW], nap_q);
              WETCs[col_idx][t*EW +: EW] <= count_etc(encode_bpr(WRegs[col_idx][t*WW +: WW], nap_q));
            end
            col_cnt <= col_cnt + NCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
